// File: rtl/debug_pkg.sv
`default_nettype none
// ============================================================================
// Module      : debug_pkg
// Description : Shared constants and state encodings for the UART debug unit.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
package debug_pkg;

  // Host command bytes
  localparam logic [7:0] CMD_START      = 8'h01;
  localparam logic [7:0] CMD_CONTINUOUS = 8'h02;
  localparam logic [7:0] CMD_STEP_MODE  = 8'h03;
  localparam logic [7:0] CMD_REPROGRAM  = 8'h05;
  localparam logic [7:0] CMD_STEP       = 8'h06;

  // All-ones halt instruction; sliced down to the datapath width (LEN <= 256)
  localparam logic [255:0] HALT_WORD = '1;

  // Controller state encoding, also driven on the mode LEDs
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_READY     = 3'd2,
    ST_RUN       = 3'd3,
    ST_STEP_WAIT = 3'd4,
    ST_STEP      = 3'd5,
    ST_SEND      = 3'd6
  } state_e;

  // Byte serializer state encoding
  typedef enum logic [1:0] {
    SER_IDLE  = 2'd0,
    SER_ISSUE = 2'd1,
    SER_WAIT  = 2'd2
  } ser_state_e;

endpackage
`default_nettype wire

// File: rtl/debug_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module      : debug_tx_serializer
// Description : Sends one LEN-bit word as LEN/8 bytes, MSB first, over the
//               UART tx_start/tx_done handshake and flags word completion.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module debug_tx_serializer
  import debug_pkg::*;
#(
  parameter int LEN = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [LEN-1:0] word_i,
  input  logic           start_i,
  input  logic           tx_done_i,
  output logic [7:0]     tx_data_o,
  output logic           tx_start_o,
  output logic           word_done_o
);

  localparam int BYTES  = LEN / 8;
  localparam int BCNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(BYTES - 1);

  ser_state_e        state_q, state_d;
  logic [LEN-1:0]    shift_q, shift_d;
  logic [BCNT_W-1:0] cnt_q, cnt_d;

  // State, shift register and byte counter; reset drops any byte in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= SER_IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  // First byte goes out in the start cycle straight from word_i so the caller's
  // word is sampled exactly when its first tx_start is raised.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    tx_start_o  = 1'b0;
    tx_data_o   = shift_q[LEN-1 -: 8];
    word_done_o = 1'b0;
    case (state_q)
      SER_IDLE: begin
        tx_data_o = 8'h00;
        if (start_i) begin
          tx_start_o = 1'b1;
          tx_data_o  = word_i[LEN-1 -: 8];
          shift_d    = word_i;
          cnt_d      = '0;
          state_d    = SER_WAIT;
        end
      end
      SER_ISSUE: begin
        tx_start_o = 1'b1;
        state_d    = SER_WAIT;
      end
      SER_WAIT: begin
        if (tx_done_i) begin
          if (cnt_q == BCNT_LAST) begin
            word_done_o = 1'b1;
            state_d     = SER_IDLE;
          end else begin
            shift_d = shift_q << 8;
            cnt_d   = cnt_q + BCNT_W'(1);
            state_d = SER_ISSUE;
          end
        end
      end
      default: state_d = SER_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/debug_unit.sv
`default_nettype none
// ============================================================================
// Module      : debug_unit
// Description : UART-driven debug controller: loads instruction memory, runs
//               the pipeline continuously or stepwise and returns dump frames.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module debug_unit
  import debug_pkg::*;
#(
  parameter  int LEN      = 32,
  parameter  int ADDR_W   = 10,
  parameter  int NUM_DUMP = 8,
  localparam int SEL_W    = (NUM_DUMP > 1) ? $clog2(NUM_DUMP) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        uart_rx_data,
  input  logic              uart_rx_valid,
  output logic [7:0]        uart_tx_data,
  output logic              uart_tx_start,
  input  logic              uart_tx_done,
  input  logic              halt,
  output logic [SEL_W-1:0]  dump_sel,
  input  logic [LEN-1:0]    dump_data,
  output logic              pipe_enable,
  output logic              pipe_reset,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [LEN-1:0]    imem_wdata,
  output logic [2:0]        mode
);

  localparam int BYTES  = LEN / 8;
  localparam int BCNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(BYTES - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
  localparam logic [SEL_W-1:0]  SEL_LAST  = SEL_W'(NUM_DUMP - 1);
  localparam logic [LEN-1:0]    HALT      = HALT_WORD[LEN-1:0];

  state_e            state_q, state_d;
  state_e            ret_q, ret_d;
  logic [LEN-1:0]    cycle_q, cycle_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN-1:0]    wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [LEN-1:0]    word_q, word_d;
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
  logic              preset_q, preset_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              cnt_phase_q, cnt_phase_d;
  logic              pending_q, pending_d;

  logic              run_en;
  logic              ser_start;
  logic              ser_done;
  logic [LEN-1:0]    ser_word;
  logic [LEN-1:0]    word_next;

  assign run_en    = (state_q == ST_RUN) || (state_q == ST_STEP);
  assign word_next = (word_q << 8) | LEN'(uart_rx_data);
  assign ser_word  = cnt_phase_q ? cycle_q : dump_data;

  debug_tx_serializer #(
    .LEN (LEN)
  ) u_ser (
    .clk         (clk),
    .reset       (reset),
    .word_i      (ser_word),
    .start_i     (ser_start),
    .tx_done_i   (uart_tx_done),
    .tx_data_o   (uart_tx_data),
    .tx_start_o  (uart_tx_start),
    .word_done_o (ser_done)
  );

  // Controller registers; reset aborts any load, run or frame in progress
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      ret_q       <= ST_IDLE;
      cycle_q     <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      word_q      <= '0;
      bcnt_q      <= '0;
      preset_q    <= 1'b0;
      sel_q       <= '0;
      cnt_phase_q <= 1'b0;
      pending_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      cycle_q     <= cycle_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      word_q      <= word_d;
      bcnt_q      <= bcnt_d;
      preset_q    <= preset_d;
      sel_q       <= sel_d;
      cnt_phase_q <= cnt_phase_d;
      pending_q   <= pending_d;
    end
  end

  // Command decode, program load, run control and frame sequencing
  always_comb begin
    state_d     = state_q;
    ret_d       = ret_q;
    cycle_d     = cycle_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = 1'b0;
    word_d      = word_q;
    bcnt_d      = bcnt_q;
    preset_d    = 1'b0;
    sel_d       = sel_q;
    cnt_phase_d = cnt_phase_q;
    pending_d   = pending_q;
    ser_start   = 1'b0;

    if (run_en) begin
      cycle_d = cycle_q + LEN'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (uart_rx_valid && uart_rx_data == CMD_START) begin
          state_d  = ST_LOAD;
          preset_d = 1'b1;
          addr_d   = '0;
          cycle_d  = '0;
          bcnt_d   = '0;
          word_d   = '0;
        end
      end
      ST_LOAD: begin
        // Cycle after a write: advance the address (saturating) and leave on
        // the halt word or once the top address has been written.
        if (we_q) begin
          if (wdata_q == HALT || addr_q == ADDR_LAST) begin
            state_d = ST_READY;
          end
          if (addr_q != ADDR_LAST) begin
            addr_d = addr_q + ADDR_W'(1);
          end
        end
        if (uart_rx_valid) begin
          word_d = word_next;
          if (bcnt_q == BCNT_LAST) begin
            we_d    = 1'b1;
            wdata_d = word_next;
            bcnt_d  = '0;
          end else begin
            bcnt_d = bcnt_q + BCNT_W'(1);
          end
        end
      end
      ST_READY: begin
        if (uart_rx_valid) begin
          if (uart_rx_data == CMD_CONTINUOUS) begin
            state_d = ST_RUN;
          end else if (uart_rx_data == CMD_STEP_MODE) begin
            state_d = ST_STEP_WAIT;
          end else if (uart_rx_data == CMD_REPROGRAM) begin
            state_d  = ST_LOAD;
            preset_d = 1'b1;
            addr_d   = '0;
            cycle_d  = '0;
            bcnt_d   = '0;
            word_d   = '0;
          end
        end
      end
      ST_RUN: begin
        if (halt) begin
          state_d     = ST_SEND;
          ret_d       = ST_READY;
          cnt_phase_d = 1'b1;
          sel_d       = '0;
          pending_d   = 1'b1;
        end
      end
      ST_STEP_WAIT: begin
        if (uart_rx_valid) begin
          if (uart_rx_data == CMD_STEP) begin
            state_d = ST_STEP;
          end else if (uart_rx_data == CMD_REPROGRAM) begin
            state_d  = ST_LOAD;
            preset_d = 1'b1;
            addr_d   = '0;
            cycle_d  = '0;
            bcnt_d   = '0;
            word_d   = '0;
          end
        end
      end
      ST_STEP: begin
        state_d     = ST_SEND;
        ret_d       = halt ? ST_READY : ST_STEP_WAIT;
        cnt_phase_d = 1'b1;
        sel_d       = '0;
        pending_d   = 1'b1;
      end
      ST_SEND: begin
        // Counter word first, then dump words 0..NUM_DUMP-1
        if (pending_q) begin
          ser_start = 1'b1;
          pending_d = 1'b0;
        end
        if (ser_done) begin
          if (cnt_phase_q) begin
            cnt_phase_d = 1'b0;
            pending_d   = 1'b1;
          end else if (sel_q == SEL_LAST) begin
            sel_d   = '0;
            state_d = ret_q;
          end else begin
            sel_d     = sel_q + SEL_W'(1);
            pending_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign dump_sel    = sel_q;
  assign pipe_enable = run_en;
  assign pipe_reset  = preset_q;
  assign imem_we     = we_q;
  assign imem_addr   = addr_q;
  assign imem_wdata  = wdata_q;
  assign mode        = state_q;

endmodule
`default_nettype wire

// File: tb/tb_debug_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_debug_unit
// Description : Self-checking bench for debug_unit (LEN=32, ADDR_W=2, NUM_DUMP=8)
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_debug_unit;

  localparam int LEN      = 32;
  localparam int ADDR_W   = 2;
  localparam int NUM_DUMP = 8;
  localparam int SEL_W    = 3;
  localparam int FRAME    = (NUM_DUMP + 1) * LEN / 8;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [7:0]        uart_rx_data = 8'h00;
  logic              uart_rx_valid = 1'b0;
  logic [7:0]        uart_tx_data;
  logic              uart_tx_start;
  logic              uart_tx_done;
  logic              halt;
  logic [SEL_W-1:0]  dump_sel;
  logic [LEN-1:0]    dump_data;
  logic              pipe_enable;
  logic              pipe_reset;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [LEN-1:0]    imem_wdata;
  logic [2:0]        mode;

  debug_unit #(.LEN(LEN), .ADDR_W(ADDR_W), .NUM_DUMP(NUM_DUMP)) dut (
    .clk(clk), .reset(reset),
    .uart_rx_data(uart_rx_data), .uart_rx_valid(uart_rx_valid),
    .uart_tx_data(uart_tx_data), .uart_tx_start(uart_tx_start), .uart_tx_done(uart_tx_done),
    .halt(halt), .dump_sel(dump_sel), .dump_data(dump_data),
    .pipe_enable(pipe_enable), .pipe_reset(pipe_reset),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata), .mode(mode)
  );

  always #5 clk = ~clk;

  // Datapath model: dump word k = base + k*0x01010101
  logic [LEN-1:0] dump_base = '0;
  assign dump_data = dump_base + LEN'(dump_sel) * 32'h0101_0101;

  logic halt_hold = 1'b0;
  logic halt_run  = 1'b0;
  assign halt = halt_hold | halt_run;

  typedef struct { logic [ADDR_W-1:0] a; logic [LEN-1:0] d; } wr_t;
  logic [7:0] tx_q[$];
  wr_t        wr_q[$];
  int en_cnt = 0, rst_pulses = 0, viol = 0, halt_at = 0;
  logic       outstanding = 1'b0;
  logic [7:0] held = 8'h00;

  int tests = 0, fails = 0;

  // Observer: records tx bytes, imem writes, enable cycles, protocol breaches
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        outstanding = 1'b0;
      end else begin
        if (uart_tx_start) begin
          if (outstanding) viol++;
          outstanding = 1'b1;
          held = uart_tx_data;
          tx_q.push_back(uart_tx_data);
        end else if (outstanding && uart_tx_data !== held) begin
          viol++;
        end
        if (uart_tx_done) outstanding = 1'b0;
        if (imem_we) wr_q.push_back('{imem_addr, imem_wdata});
        if (pipe_enable) en_cnt++;
        if (pipe_enable && mode != 3'd3 && mode != 3'd5) viol++;
        if (pipe_reset) begin
          rst_pulses++;
          if (pipe_enable) viol++;
        end
      end
      halt_run = (halt_at != 0) && (en_cnt >= halt_at) && (mode == 3'd3);
    end
  end

  // UART transmitter model: tx_done 1..3 cycles after each tx_start
  initial begin
    uart_tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (uart_tx_start && reset) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1 uart_tx_done = 1'b1;
        @(posedge clk);
        #1 uart_tx_done = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string t);
    check({t, " tx_data"}, 64'(uart_tx_data), 0);
    check({t, " tx_start"}, 64'(uart_tx_start), 0);
    check({t, " dump_sel"}, 64'(dump_sel), 0);
    check({t, " pipe_enable"}, 64'(pipe_enable), 0);
    check({t, " pipe_reset"}, 64'(pipe_reset), 0);
    check({t, " imem_we"}, 64'(imem_we), 0);
    check({t, " imem_addr"}, 64'(imem_addr), 0);
    check({t, " imem_wdata"}, 64'(imem_wdata), 0);
    check({t, " mode"}, 64'(mode), 0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    uart_rx_data  = b;
    uart_rx_valid = 1'b1;
    @(posedge clk); #1;
    uart_rx_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_frame(input string name);
    int n;
    n = 0;
    while (mode != 3'd6 && n < 300) begin @(posedge clk); #1; n++; end
    check({name, " enter SEND"}, 64'(n < 300), 1);
    n = 0;
    while (mode == 3'd6 && n < 5000) begin @(posedge clk); #1; n++; end
    check({name, " leave SEND"}, 64'(n < 5000), 1);
  endtask

  task automatic check_frame(input string name, input int base, input logic [LEN-1:0] count);
    logic [LEN-1:0] w;
    int idx;
    check({name, " byte count"}, 64'(tx_q.size() - base), FRAME);
    for (int k = 0; k <= NUM_DUMP; k++) begin
      w = (k == 0) ? count : dump_base + LEN'(k - 1) * 32'h0101_0101;
      for (int j = 0; j < LEN / 8; j++) begin
        idx = base + k * (LEN / 8) + j;
        if (idx < tx_q.size())
          check($sformatf("%s byte%0d", name, idx - base), 64'(tx_q[idx]),
                64'(8'(w >> (8 * (LEN / 8 - 1 - j)))));
      end
    end
  endtask

  typedef struct { logic [7:0] b; logic [2:0] m; } vec_t;
  vec_t tbl [32];
  wr_t  exp_wr [6];

  initial begin
    int base, e0, n, w0;
    logic [LEN-1:0] w;
    logic [7:0] junk;

    tbl = '{'{8'h02,3'd0}, '{8'h07,3'd0}, '{8'h01,3'd1},
            '{8'h20,3'd1}, '{8'h01,3'd1}, '{8'h00,3'd1}, '{8'h05,3'd1},
            '{8'hFF,3'd1}, '{8'hFF,3'd1}, '{8'hFF,3'd1}, '{8'hFF,3'd2},
            '{8'h01,3'd2}, '{8'h06,3'd2}, '{8'h03,3'd4}, '{8'h02,3'd4}, '{8'h05,3'd1},
            '{8'h11,3'd1}, '{8'h22,3'd1}, '{8'h33,3'd1}, '{8'h44,3'd1},
            '{8'h55,3'd1}, '{8'h66,3'd1}, '{8'h77,3'd1}, '{8'h88,3'd1},
            '{8'h99,3'd1}, '{8'hAA,3'd1}, '{8'hBB,3'd1}, '{8'hCC,3'd1},
            '{8'h0D,3'd1}, '{8'hDE,3'd1}, '{8'hEF,3'd1}, '{8'hF0,3'd2}};
    exp_wr = '{'{2'd0, 32'h2001_0005}, '{2'd1, 32'hFFFF_FFFF},
               '{2'd0, 32'h1122_3344}, '{2'd1, 32'h5566_7788},
               '{2'd2, 32'h99AA_BBCC}, '{2'd3, 32'h0DDE_EFF0}};

    // Reset state
    repeat (3) @(posedge clk);
    #1 check_zero("reset");
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Command table: load, ignored bytes, mode switches, reprogram, full memory
    for (int i = 0; i < 32; i++) begin
      send_byte(tbl[i].b);
      check($sformatf("vec%0d mode", i), 64'(mode), 64'(tbl[i].m));
    end
    check("load writes", 64'(wr_q.size()), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < wr_q.size()) begin
        check($sformatf("wr%0d addr", i), 64'(wr_q[i].a), 64'(exp_wr[i].a));
        check($sformatf("wr%0d data", i), 64'(wr_q[i].d), 64'(exp_wr[i].d));
      end
    end
    check("full addr held", 64'(imem_addr), 3);
    check("pipe_reset pulses", 64'(rst_pulses), 2);
    check("no enable in load", 64'(en_cnt), 0);

    // Step mode: three steps give counts 1,2,3 and return to STEP_WAIT
    send_byte(8'h03);
    check("step_mode mode", 64'(mode), 4);
    for (int s = 1; s <= 3; s++) begin
      dump_base = $urandom;
      base = tx_q.size();
      e0 = en_cnt;
      send_byte(8'h06);
      wait_frame($sformatf("step%0d", s));
      check($sformatf("step%0d enables", s), 64'(en_cnt - e0), 1);
      check_frame($sformatf("step%0d", s), base, LEN'(s));
      check($sformatf("step%0d mode", s), 64'(mode), 4);
    end

    // Step with halt high returns to READY; a further STEP is ignored
    halt_hold = 1'b1;
    dump_base = $urandom;
    base = tx_q.size();
    e0 = en_cnt;
    send_byte(8'h06);
    wait_frame("halt step");
    check("halt step enables", 64'(en_cnt - e0), 1);
    check_frame("halt step", base, 4);
    check("halt step mode", 64'(mode), 2);
    halt_hold = 1'b0;
    e0 = en_cnt;
    send_byte(8'h06);
    check("stray step mode", 64'(mode), 2);
    check("stray step enables", 64'(en_cnt - e0), 0);

    // Random unknown bytes in READY are ignored
    for (int i = 0; i < 4; i++) begin
      junk = 8'($urandom_range(7, 255));
      send_byte(junk);
      check($sformatf("junk %0h mode", junk), 64'(mode), 2);
    end

    // Reprogram with random non-halt words until memory is full
    n = rst_pulses;
    w0 = wr_q.size();
    send_byte(8'h05);
    check("reprogram pulse", 64'(rst_pulses - n), 1);
    for (int i = 0; i < 4; i++) begin
      w = LEN'($urandom) & 32'h7FFF_FFFF;
      exp_wr[i] = '{ADDR_W'(i), w};
      for (int j = 3; j >= 0; j--) send_byte(8'(w >> (8 * j)));
    end
    check("reprogram mode", 64'(mode), 2);
    check("reprogram writes", 64'(wr_q.size() - w0), 4);
    for (int i = 0; i < 4; i++) begin
      if (w0 + i < wr_q.size()) begin
        check($sformatf("rp%0d addr", i), 64'(wr_q[w0 + i].a), 64'(exp_wr[i].a));
        check($sformatf("rp%0d data", i), 64'(wr_q[w0 + i].d), 64'(exp_wr[i].d));
      end
    end

    // Continuous run halted after 37 enabled cycles
    dump_base = $urandom;
    base = tx_q.size();
    e0 = en_cnt;
    halt_at = en_cnt + 37;
    send_byte(8'h02);
    wait_frame("run37");
    halt_at = 0;
    check("run37 enables", 64'(en_cnt - e0), 37);
    check_frame("run37", base, 37);
    check("run37 mode", 64'(mode), 2);

    // Random-length continuous run; counter keeps accumulating
    n = $urandom_range(2, 20);
    dump_base = $urandom;
    base = tx_q.size();
    e0 = en_cnt;
    halt_at = en_cnt + n;
    send_byte(8'h02);
    wait_frame("runN");
    halt_at = 0;
    check("runN enables", 64'(en_cnt - e0), 64'(n));
    check_frame("runN", base, LEN'(37 + n));

    // Reset during the 10th byte of a frame
    dump_base = $urandom;
    base = tx_q.size();
    halt_at = en_cnt + 5;
    send_byte(8'h02);
    n = 0;
    while (tx_q.size() < base + 10 && n < 2000) begin @(negedge clk); #1; n++; end
    check("reach byte 10", 64'(n < 2000), 1);
    reset = 1'b0;
    #1 check_zero("midframe reset");
    halt_at = 0;
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("no tx after reset", 64'(tx_q.size() - base), 10);
    check("idle after reset", 64'(mode), 0);
    e0 = en_cnt;
    send_byte(8'h02);
    check("continuous in idle mode", 64'(mode), 0);
    check("continuous in idle enables", 64'(en_cnt - e0), 0);

    check("handshake violations", 64'(viol), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
